stage2_runner: RTL and testbench
================================

Name: stage2_runner

Overview:
- Sequential game stage that runs a fixed number of player rounds and produces the qualification result consumed by stage 3.
- Takes pass1 from stage 1 and plays ROUNDS rounds of 3-bit jump inputs against a per-round luck value.
- Outputs are pass2 (stage cleared) and bonus2 (saturating 2-bit coin count), which feed stage 3's pass2/bonus2 inputs directly.

Parameters:
- ROUNDS, 4, number of valid rounds required to clear the stage (1..15).
- LIVES, 2, hits tolerated before failure (1..3); the stage fails when the lives counter reaches 0.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- pass1  input  1  stage 1 result; latched on accepted start
- valid  input  1  jump/luck2 carry a round this cycle
- jump  input  3  player jump value for the round
- luck2  input  3  luck value for the round
- done  output  1  run finished; pass2/bonus2 are meaningful while high
- pass2  output  1  stage 2 cleared (registered)
- bonus2  output  2  coins collected, saturating at 3 (registered)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, done=0, pass2=0, bonus2=0, round_cnt=0, coin_cnt=0, lives=LIVES, pass1_q=0. Reset mid-run aborts immediately to these values.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, start=1:
  - next state RUN; pass1_q<=pass1.
  - clear round_cnt and coin_cnt; lives<=LIVES.
  - done, pass2, bonus2 <= 0.
- RUN, pass1_q=0: next cycle DONE with pass2=0, bonus2=0; valid is ignored.
- RUN, valid=1, rule priority per round:
  - jump==0: fail. Next cycle DONE, pass2=0, bonus2=0.
  - Otherwise coin = ((jump ^ luck) == 3'b011); coin_cnt saturates at 3.
  - Otherwise hit = (jump <= 2) && (jump == luck); lives decrements by 1. Coin and hit in the same round both apply.
  - If lives reaches 0 on this round: DONE, pass2=0, bonus2=0.
  - Otherwise round_cnt++. If round_cnt reaches ROUNDS: DONE, pass2=1, bonus2=updated coin_cnt (includes this round's coin).
- RUN, valid=0: hold all state.
- Latency: final round sampled at edge t gives done=1, pass2 and bonus2 valid after edge t (one cycle).
- start during RUN is ignored. valid in IDLE or DONE is ignored.
- DONE: done, pass2 and bonus2 hold until the next accepted start or reset.
- Arithmetic and width:
  - round_cnt is 4 bits.
  - lives is 2 bits; it never underflows because the transition occurs at 0.
  - coin_cnt is 2 bits, saturating.

Optional Feature:
- Macro: STAGE2_LUCK_LFSR_EN.
- Defined:
  - luck is an internal 3-bit LFSR, polynomial x^3+x^2+1, seed 3'b101.
  - The LFSR reloads its seed on reset and on accepted start, and advances on each valid round in RUN.
  - The luck2 port is present but ignored.
- Undefined: luck = luck2 port; no LFSR logic.

Decomposition:
- Shared package stage_pkg:
  - state enum {IDLE, RUN, DONE}
  - COIN_PATTERN=3'b011, HIT_MAX=3'd2, BONUS_MAX=2'd3, LFSR_SEED=3'b101
- One natural sub-module: luck_lfsr (3-bit LFSR with load/advance). It is instantiated only under STAGE2_LUCK_LFSR_EN.

Test Plan:
- Clear with coins: LIVES=2, ROUNDS=4, luck2=3'b001, pass1=1, jumps 2,5,2,6 on consecutive valid cycles -> done=1 one cycle after 4th round, pass2=1, bonus2=2.
- Lives exhausted: luck2=1, jumps 1,1 -> done=1 after 2nd round, pass2=0, bonus2=0, later valid rounds ignored.
- Zero jump: luck2=1, jumps 3,0 -> DONE after round 2, pass2=0, bonus2=0.
- Saturation and gaps: luck2=1, jump 2 on 4 rounds interleaved with valid=0 cycles -> pass2=1, bonus2=3, done only after 4th valid.
- Upstream fail: pass1=0 at start -> done=1 two cycles after start, pass2=0; valid inputs have no effect.
- Reset mid-run: rst_n low during RUN after 2 rounds -> all outputs 0 asynchronously, state IDLE; fresh start runs the full ROUNDS.

Source files
------------

// File: rtl/stage_pkg.sv
// stage_pkg: shared state encoding and game constants for the stage 2 runner.
package stage_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [2:0] COIN_PATTERN = 3'b011;
    localparam logic [2:0] HIT_MAX      = 3'd2;
    localparam logic [1:0] BONUS_MAX    = 2'd3;
    localparam logic [2:0] LFSR_SEED    = 3'b101;
endpackage

// File: rtl/luck_lfsr.sv
// luck_lfsr: 3-bit Fibonacci LFSR (x^3+x^2+1) producing per-round luck values.
module luck_lfsr
    import stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    output logic [2:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= LFSR_SEED;
        else if (load) q <= LFSR_SEED;
        else if (advance) q <= {q[1:0], q[2] ^ q[1]};
    end
endmodule

// File: rtl/stage2_runner.sv
// stage2_runner: plays ROUNDS jump rounds and reports pass2/bonus2 to stage 3.
// Define STAGE2_LUCK_LFSR_EN to draw luck from an internal LFSR instead of luck2.
module stage2_runner
    import stage_pkg::*;
#(
    parameter int ROUNDS = 4,
    parameter int LIVES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pass1,
    input  logic       valid,
    input  logic [2:0] jump,
    input  logic [2:0] luck2,
    output logic       done,
    output logic       pass2,
    output logic [1:0] bonus2
);
    state_t     state;
    logic [3:0] round_cnt, round_nxt;
    logic [1:0] coin_cnt, coin_nxt, lives, lives_nxt;
    logic       pass1_q, coin, hit, accept;
    logic [2:0] luck;

    assign accept = start && (state != RUN);

`ifdef STAGE2_LUCK_LFSR_EN
    luck_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .advance (state == RUN && valid),
        .q       (luck)
    );
`else
    assign luck = luck2;
`endif

    always_comb begin
        coin      = (jump ^ luck) == COIN_PATTERN;
        hit       = (jump <= HIT_MAX) && (jump == luck);
        coin_nxt  = (coin && coin_cnt != BONUS_MAX) ? coin_cnt + 2'd1 : coin_cnt;
        lives_nxt = hit ? lives - 2'd1 : lives;
        round_nxt = round_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            done      <= 1'b0;
            pass2     <= 1'b0;
            bonus2    <= 2'd0;
            round_cnt <= 4'd0;
            coin_cnt  <= 2'd0;
            lives     <= 2'(LIVES);
            pass1_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= RUN;
                    pass1_q   <= pass1;
                    round_cnt <= 4'd0;
                    coin_cnt  <= 2'd0;
                    lives     <= 2'(LIVES);
                    done      <= 1'b0;
                    pass2     <= 1'b0;
                    bonus2    <= 2'd0;
                end
                RUN: if (!pass1_q || (valid && jump == 3'd0)) begin
                    state  <= DONE;
                    done   <= 1'b1;
                    pass2  <= 1'b0;
                    bonus2 <= 2'd0;
                end else if (valid) begin
                    coin_cnt <= coin_nxt;
                    lives    <= lives_nxt;
                    // Losing the last life fails the stage even on the final round.
                    if (lives_nxt == 2'd0) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        pass2  <= 1'b0;
                        bonus2 <= 2'd0;
                    end else begin
                        round_cnt <= round_nxt;
                        if (round_nxt == 4'(ROUNDS)) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            pass2  <= 1'b1;
                            bonus2 <= coin_nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stage2_runner.sv
// tb_stage2_runner: randomized and directed bench scored against a round-history model.
module tb_stage2_runner;
    localparam int ROUNDS = 4;
    localparam int LIVES  = 2;

    logic       clk = 0, rst_n = 0, start = 0, pass1 = 0, valid = 0;
    logic [2:0] jump = 0, luck2 = 0;
    logic       done, pass2;
    logic [1:0] bonus2;
    int         checks = 0, errors = 0;

    stage2_runner #(.ROUNDS(ROUNDS), .LIVES(LIVES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pass1(pass1), .valid(valid),
        .jump(jump), .luck2(luck2), .done(done), .pass2(pass2), .bonus2(bonus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic lit(input string name, input int d, input int p, input int b);
        chk({name, "_done"}, int'(done), d);
        chk({name, "_pass2"}, int'(pass2), p);
        chk({name, "_bonus2"}, int'(bonus2), b);
    endtask

    // Model: a run is the list of rounds played so far; the outcome is recomputed from the whole list.
    bit m_run, m_p1;
    int e_done, e_pass, e_bonus;
    int jq[$], lq[$];

    function automatic void score(output int st, output int coins);
        int hits = 0;
        coins = 0;
        st = 0;
        for (int i = 0; i < jq.size(); i++) begin
            if (jq[i] == 0) begin st = 1; return; end
            if ((jq[i] ^ lq[i]) == 3) coins = (coins < 3) ? coins + 1 : 3;
            if (jq[i] <= 2 && jq[i] == lq[i]) hits++;
            if (hits >= LIVES) begin st = 1; return; end
            if (i + 1 == ROUNDS) begin st = 2; return; end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int st, c;
        if (!rst_n) begin
            m_run <= 0; e_done <= 0; e_pass <= 0; e_bonus <= 0;
            jq.delete(); lq.delete();
        end else if (!m_run) begin
            if (start) begin
                m_run <= 1; m_p1 <= pass1; e_done <= 0; e_pass <= 0; e_bonus <= 0;
                jq.delete(); lq.delete();
            end
        end else if (!m_p1) begin
            m_run <= 0; e_done <= 1; e_pass <= 0; e_bonus <= 0;
        end else if (valid) begin
            jq.push_back(int'(jump));
            lq.push_back(int'(luck2));
            score(st, c);
            if (st != 0) begin
                m_run <= 0; e_done <= 1;
                e_pass <= (st == 2) ? 1 : 0;
                e_bonus <= (st == 2) ? c : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_done", int'(done), e_done);
            chk("cyc_pass2", int'(pass2), e_pass);
            chk("cyc_bonus2", int'(bonus2), e_bonus);
        end
    end

    task automatic do_start(input logic p);
        start = 1; pass1 = p; valid = 1'($urandom_range(0, 1)); jump = 3'($urandom_range(0, 7));
        @(negedge clk);
        start = 0; valid = 0;
    endtask

    task automatic rnd(input logic [2:0] j, input logic [2:0] l, input logic v);
        start = 0; valid = v; jump = j; luck2 = l;
        @(negedge clk);
        valid = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        lit("reset", 0, 0, 0);
        rst_n = 1;
        @(negedge clk);
        lit("idle", 0, 0, 0);
        // Clear with coins: jumps 2,5,2,6 against luck 1 give two coins.
        do_start(1);
        rnd(2, 1, 1); rnd(5, 1, 1); rnd(2, 1, 1);
        lit("clear_mid", 0, 0, 0);
        rnd(6, 1, 1);
        lit("clear", 1, 1, 2);
        // Lives exhausted, then further rounds are ignored.
        do_start(1);
        rnd(1, 1, 1); rnd(1, 1, 1);
        lit("lives", 1, 0, 0);
        rnd(2, 1, 1); rnd(2, 1, 1); rnd(2, 1, 1);
        lit("lives_hold", 1, 0, 0);
        // Zero jump fails immediately.
        do_start(1);
        rnd(3, 1, 1); rnd(0, 1, 1);
        lit("zero", 1, 0, 0);
        // Coin saturation with idle gaps.
        do_start(1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) lit("sat_mid", 0, 0, 0);
            rnd(2, 1, 1);
            if (i < 3) rnd(2, 1, 0);
        end
        lit("sat", 1, 1, 3);
        // Upstream fail.
        do_start(0);
        lit("up_run", 0, 0, 0);
        rnd(2, 1, 1);
        lit("up_done", 1, 0, 0);
        // Reset mid-run, then a full fresh run.
        do_start(1);
        rnd(2, 1, 1); rnd(2, 1, 1);
        #3 rst_n = 0;
        #1 lit("async_rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1;
        do_start(1);
        rnd(5, 1, 1); rnd(5, 1, 1); rnd(5, 1, 1);
        lit("fresh_mid", 0, 0, 0);
        rnd(5, 1, 1);
        lit("fresh", 1, 1, 0);
        // Randomized runs, including ignored starts during RUN.
        for (int r = 0; r < 40; r++) begin
            do_start($urandom_range(0, 4) != 0);
            for (int c = 0; c < 60 && !done; c++) begin
                start = ($urandom_range(0, 9) == 0);
                valid = 1'($urandom_range(0, 1));
                jump  = 3'($urandom_range(0, 7));
                luck2 = ($urandom_range(0, 3) == 0) ? jump : 3'($urandom_range(0, 7));
                @(negedge clk);
            end
            start = 0; valid = 0;
            @(negedge clk);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
